// File: rtl/key_expansion_ctrl_if.sv
// key_expansion_ctrl_if: key-load and round-key read bus of the AES-128 key
// expansion controller.
//   master: drives start/key_in and rd_en/rd_idx, observes status and read data
//   slave : the controller; returns busy/done/keys_valid and rd_valid/rd_key/rd_err
interface key_expansion_ctrl_if #(
    parameter int unsigned KEY_W = 128
);
    localparam int unsigned IDX_W = 4;

    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             done;
    logic             keys_valid;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [KEY_W-1:0] rd_key;
    logic             rd_err;

    modport master (
        output start, key_in, rd_en, rd_idx,
        input  busy, done, keys_valid, rd_valid, rd_key, rd_err
    );

    modport slave (
        input  start, key_in, rd_en, rd_idx,
        output busy, done, keys_valid, rd_valid, rd_key, rd_err
    );
endinterface

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: sequential AES-128 key schedule. One round key is derived
// per cycle (rounds 1..10) from the previous one and stored with the cipher key
// in an 11-entry register file, served through a registered read port.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.start/key_in        : expansion request, sampled only in IDLE
//   bus.busy/done/keys_valid: expansion status (registered)
//   bus.rd_en/rd_idx        : read request for slot 0..10
//   bus.rd_valid/rd_key/rd_err : read response, one cycle after rd_en
module key_expansion_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_expansion_ctrl_if.slave  bus
);
    localparam int unsigned NUM_SLOTS  = NUM_ROUNDS + 1;
    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (a^254, with 0 -> 0) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Combinational round-key generator: derives round key `round` from its predecessor
    function automatic logic [KEY_W-1:0] round_key(input logic [KEY_W-1:0] key,
                                                   input logic [CNT_W-1:0] round);
        logic [31:0] w0, w1, w2, w3, rot, temp;
        logic [31:0] n0, n1, n2, n3;
        w0   = key[127:96];
        w1   = key[95:64];
        w2   = key[63:32];
        w3   = key[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon(round), 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   round_cnt_q, round_cnt_d;
    logic [KEY_W-1:0]   cur_key_q, cur_key_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0]   slot_q [NUM_SLOTS];

    logic               slot_we_c;
    logic [CNT_W-1:0]   slot_widx_c;
    logic [KEY_W-1:0]   slot_wdata_c;
    logic [KEY_W-1:0]   rk_out_c;
    logic [KEY_W-1:0]   rd_slot_c;

    logic               rd_valid_q;
    logic [KEY_W-1:0]   rd_key_q;
    logic               rd_err_q;

    assign rk_out_c = round_key(cur_key_q, round_cnt_q);

    // FSM state and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            round_cnt_q  <= '0;
            cur_key_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_cnt_q  <= round_cnt_d;
            cur_key_q    <= cur_key_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    // Next-state, counter and slot-write decode
    always_comb begin
        state_d      = state_q;
        round_cnt_d  = round_cnt_q;
        cur_key_d    = cur_key_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        slot_we_c    = 1'b0;
        slot_widx_c  = round_cnt_q;
        slot_wdata_c = rk_out_c;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = EXPAND;
                    round_cnt_d  = CNT_W'(1);
                    cur_key_d    = bus.key_in;
                    keys_valid_d = 1'b0;
                    slot_we_c    = 1'b1;
                    slot_widx_c  = '0;
                    slot_wdata_c = bus.key_in;
                end
            end
            EXPAND: begin
                slot_we_c = 1'b1;
                cur_key_d = rk_out_c;
                if (round_cnt_q == LAST_ROUND) begin
                    state_d      = IDLE;
                    round_cnt_d  = '0;
                    keys_valid_d = 1'b1;
                    done_d       = 1'b1;
                end else begin
                    round_cnt_d = round_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == EXPAND);
    end

    // Round-key register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_we_c && (slot_widx_c == CNT_W'(i))) slot_q[i] <= slot_wdata_c;
            end
        end
    end

    // Read mux; out-of-range indices select zero
    always_comb begin
        rd_slot_c = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.rd_idx == CNT_W'(i)) rd_slot_c = slot_q[i];
        end
    end

    // Registered read port; uses pre-edge keys_valid, so reads racing T0/T10 see the old status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_key_q   <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (keys_valid_q && (bus.rd_idx <= LAST_ROUND)) begin
                    rd_key_q <= rd_slot_c;
                    rd_err_q <= 1'b0;
                end else begin
                    rd_key_q <= '0;
                    rd_err_q <= 1'b1;
                end
            end else begin
                rd_err_q <= 1'b0;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_key     = rd_key_q;
    assign bus.rd_err     = rd_err_q;
endmodule
